univ_shift_reg: RTL and testbench
=================================

Name: univ_shift_reg

Overview:
Parametrised universal shift register. It generalises the team's 8-bit serial-in shift register to WIDTH bits. It adds parallel load, left/right shift, rotate, arithmetic shift and clear. Multi-step shifts run from a single command via a valid/ready handshake, with busy/done status. It sits between a command-issuing controller and serial/parallel datapaths such as SPI-style serialisers and CRC/LFSR preloads.

Parameters:
WIDTH, 8, register width in bits (>= 2)
CNT_W, 4, width of the shift-amount field; max burst = 2**CNT_W - 1 steps

Ports:
clk  in  1  clock; all state updates on its rising edge
clr  in  1  asynchronous, active-low reset; clears all state immediately when low
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command (= state IDLE)
op  in  3  operation code, sampled on acceptance
amount  in  CNT_W  shift step count, sampled on acceptance
pdata  in  WIDTH  parallel load data, sampled on acceptance
si_l  in  1  serial in, enters q[0] on SHL
si_r  in  1  serial in, enters q[WIDTH-1] on SHR
q  out  WIDTH  register contents
so_l  out  1  q[WIDTH-1] (combinational from q)
so_r  out  1  q[0] (combinational from q)
busy  out  1  multi-step shift in progress
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (clr low, asynchronous):
  - q = 0, busy = 0, done = 0, cmd_ready = 1, step counter = 0, state IDLE.
  - Reset mid-burst aborts the burst. No done pulse is produced for the aborted command.
- Accept: cmd_valid & cmd_ready at a rising edge. op, amount and pdata are latched. cmd_valid with cmd_ready low is ignored; no queuing.
- Opcodes:
  - 0 NOP: q unchanged.
  - 1 LOAD: q <= pdata.
  - 2 SHL: q <= {q[WIDTH-2:0], si_l}.
  - 3 SHR: q <= {si_r, q[WIDTH-1:1]}.
  - 4 ROL: q <= {q[WIDTH-2:0], q[WIDTH-1]}.
  - 5 ROR: q <= {q[0], q[WIDTH-1:1]}.
  - 6 ASR: q <= {q[WIDTH-1], q[WIDTH-1:1]}.
  - 7 CLEAR: q <= 0.
- Single-cycle ops (NOP, LOAD, CLEAR, and any shift op with amount = 0):
  - Update at the accept edge; amount = 0 means q is unchanged.
  - done = 1 for exactly the next cycle.
  - busy stays 0.
- Shift ops with amount = N >= 1:
  - Step 1 happens at the accept edge; steps 2..N at the following N-1 edges.
  - If N = 1: behaves as a single-cycle op.
  - If N >= 2: state -> RUN and busy = 1 from the cycle after accept. Counter loads N-1 and decrements once per step.
  - busy falls and done = 1 in the cycle after the edge performing step N. Total command latency = N cycles to done.
- si_l/si_r are sampled live at every step edge, not latched. A different serial bit can therefore be fed each cycle.
- N larger than WIDTH is legal. Every step is executed literally, e.g. ROL by WIDTH+1 equals ROL by 1.
- State machine: IDLE -> RUN on accept of a shift with N >= 2. RUN -> IDLE on the edge that performs step N.
- done and new acceptance may coincide: in the done cycle cmd_ready = 1, so back-to-back commands issue with zero bubbles.
- q, busy and done are registered. so_l, so_r and cmd_ready are combinational from registers only, with no input-to-output combinational path.

Decomposition:
- Shared package shift_pkg holds:
  - enum typedef shift_op_e {OP_NOP, OP_LOAD, OP_SHL, OP_SHR, OP_ROL, OP_ROR, OP_ASR, OP_CLR} (3 bits);
  - state typedef {ST_IDLE, ST_RUN}.
- Sub-module shift_step: purely combinational next-q function of (op, q, si_l, si_r, pdata). It is instantiated once and used for both the accept edge and the RUN steps.

Test Plan:
- Reset: clr low mid-simulation while busy -> q = 0x00, busy = 0, done = 0, cmd_ready = 1 immediately, before any clk edge.
- LOAD 0xA5, then ROL amount 3 -> busy high for 2 cycles, q = 0x2D, done pulses once 3 cycles after accept.
- LOAD 0x80, ASR amount 7 -> q = 0xFF. Then SHR amount 1 with si_r = 0 -> q = 0x7F, busy never rises, done 1 cycle after accept.
- Serial fill: CLEAR, then SHL amount 8 with si_l driven 1,0,1,1,0,0,1,0 on successive steps -> q = 0xB2, so_l sequence observable each cycle.
- Back-to-back: issue ROR amount 2 with cmd_valid held high and the next command LOAD 0x3C presented in the done cycle -> LOAD accepted in that cycle, q = 0x3C next cycle. cmd_valid while busy is ignored (q unaffected).
- Edge amounts: SHL amount 0 -> q unchanged, done pulse. ROL amount 15 on 0x01 -> q = 0x80 after 15 steps.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types for the universal shift register: opcodes, FSM states and
// a helper that classifies the multi-step shift operations.
package shift_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_LOAD = 3'd1,
    OP_SHL  = 3'd2,
    OP_SHR  = 3'd3,
    OP_ROL  = 3'd4,
    OP_ROR  = 3'd5,
    OP_ASR  = 3'd6,
    OP_CLR  = 3'd7
  } shift_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } shift_state_e;

  function automatic logic is_shift(input shift_op_e op_i);
    return (op_i == OP_SHL) || (op_i == OP_SHR) || (op_i == OP_ROL) ||
           (op_i == OP_ROR) || (op_i == OP_ASR);
  endfunction

endpackage

// File: rtl/shift_step.sv
// One step of the register datapath: next contents for a given opcode.
// Shared by the accept edge and every RUN step.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  shift_op_e          op,
  input  logic [WIDTH-1:0]   q_in,
  input  logic               si_l,
  input  logic               si_r,
  input  logic [WIDTH-1:0]   pdata,
  output logic [WIDTH-1:0]   q_out
);

  always_comb begin
    q_out = q_in;
    case (op)
      OP_NOP:  q_out = q_in;
      OP_LOAD: q_out = pdata;
      OP_SHL:  q_out = {q_in[WIDTH-2:0], si_l};
      OP_SHR:  q_out = {si_r, q_in[WIDTH-1:1]};
      OP_ROL:  q_out = {q_in[WIDTH-2:0], q_in[WIDTH-1]};
      OP_ROR:  q_out = {q_in[0], q_in[WIDTH-1:1]};
      OP_ASR:  q_out = {q_in[WIDTH-1], q_in[WIDTH-1:1]};
      OP_CLR:  q_out = '0;
      default: q_out = q_in;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with a valid/ready command port; multi-step
// shifts run one step per clock, with busy/done status.
//
//   state   | meaning
//   ST_IDLE | ready for a command; single-cycle ops and step 1 happen here
//   ST_RUN  | executing steps 2..N of a shift burst, commands ignored
module univ_shift_reg
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         op,
  input  logic [CNT_W-1:0]   amount,
  input  logic [WIDTH-1:0]   pdata,
  input  logic               si_l,
  input  logic               si_r,
  output logic [WIDTH-1:0]   q,
  output logic               so_l,
  output logic               so_r,
  output logic               busy,
  output logic               done
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  shift_state_e      state_q, state_d;
  shift_op_e         op_q, op_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  reg_q, reg_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  shift_op_e         op_in;
  shift_op_e         step_op;
  logic              accept;

  assign op_in  = shift_op_e'(op);
  assign accept = cmd_valid && (state_q == ST_IDLE);

  shift_step #(.WIDTH(WIDTH)) u_step (
    .op    (step_op),
    .q_in  (reg_q),
    .si_l  (si_l),
    .si_r  (si_r),
    .pdata (pdata),
    .q_out (reg_d)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NOP;
      cnt_q   <= '0;
      reg_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      reg_q   <= reg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and step selection; cnt_q holds steps still to run.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    step_op = OP_NOP;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d = op_in;
          if (is_shift(op_in) && (amount == '0)) begin
            step_op = OP_NOP;
          end else begin
            step_op = op_in;
          end
          if (is_shift(op_in) && (amount > CNT_ONE)) begin
            state_d = ST_RUN;
            cnt_d   = amount - CNT_ONE;
            busy_d  = 1'b1;
          end else begin
            done_d  = 1'b1;
          end
        end
      end
      ST_RUN: begin
        step_op = op_q;
        cnt_d   = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == ST_IDLE);
    q         = reg_q;
    so_l      = reg_q[WIDTH-1];
    so_r      = reg_q[0];
    busy      = busy_q;
    done      = done_q;
  end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg (WIDTH=8, CNT_W=4) with hand-computed
// expected values checked by immediate assertions.
module tb_univ_shift_reg;

  localparam logic [2:0] C_NOP  = 3'd0;
  localparam logic [2:0] C_LOAD = 3'd1;
  localparam logic [2:0] C_SHL  = 3'd2;
  localparam logic [2:0] C_SHR  = 3'd3;
  localparam logic [2:0] C_ROL  = 3'd4;
  localparam logic [2:0] C_ROR  = 3'd5;
  localparam logic [2:0] C_ASR  = 3'd6;
  localparam logic [2:0] C_CLR  = 3'd7;

  logic       clk = 1'b0;
  logic       clr;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] op;
  logic [3:0] amount;
  logic [7:0] pdata;
  logic       si_l;
  logic       si_r;
  logic [7:0] q;
  logic       so_l;
  logic       so_r;
  logic       busy;
  logic       done;

  int checks   = 0;
  int failures = 0;

  univ_shift_reg #(.WIDTH(8), .CNT_W(4)) dut (
    .clk       (clk),
    .clr       (clr),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .op        (op),
    .amount    (amount),
    .pdata     (pdata),
    .si_l      (si_l),
    .si_r      (si_r),
    .q         (q),
    .so_l      (so_l),
    .so_r      (so_r),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [3:0] a, input logic [7:0] d);
    cmd_valid = 1'b1;
    op        = o;
    amount    = a;
    pdata     = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic chk_status(input string tag, input logic [7:0] eq,
                            input logic eb, input logic ed, input logic er);
    chk({tag, "_q"},     32'(q),         32'(eq));
    chk({tag, "_busy"},  32'(busy),      32'(eb));
    chk({tag, "_done"},  32'(done),      32'(ed));
    chk({tag, "_ready"}, 32'(cmd_ready), 32'(er));
  endtask

  initial begin
    logic [7:0] bits;
    logic [7:0] exp_q;

    clr       = 1'b0;
    cmd_valid = 1'b0;
    op        = C_NOP;
    amount    = 4'd0;
    pdata     = 8'h00;
    si_l      = 1'b0;
    si_r      = 1'b0;

    #2;
    chk_status("reset", 8'h00, 1'b0, 1'b0, 1'b1);
    #10 clr = 1'b1;
    tick();

    // LOAD A5 then ROL 3
    issue(C_LOAD, 4'd0, 8'hA5);
    chk_status("load_a5", 8'hA5, 1'b0, 1'b1, 1'b1);
    issue(C_ROL, 4'd3, 8'h00);
    chk_status("rol3_s1", 8'h4B, 1'b1, 1'b0, 1'b0);
    tick();
    chk_status("rol3_s2", 8'h96, 1'b1, 1'b0, 1'b0);
    tick();
    chk_status("rol3_done", 8'h2D, 1'b0, 1'b1, 1'b1);
    tick();
    chk("rol3_done_once", 32'(done), 32'(1'b0));

    // LOAD 80, ASR 7, then SHR 1
    issue(C_LOAD, 4'd0, 8'h80);
    chk("so_l_80", 32'(so_l), 32'(1'b1));
    chk("so_r_80", 32'(so_r), 32'(1'b0));
    issue(C_ASR, 4'd7, 8'h00);
    chk_status("asr7_s1", 8'hC0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) tick();
    chk_status("asr7_done", 8'hFF, 1'b0, 1'b1, 1'b1);
    si_r = 1'b0;
    issue(C_SHR, 4'd1, 8'h00);
    chk_status("shr1", 8'h7F, 1'b0, 1'b1, 1'b1);
    chk("so_r_7f", 32'(so_r), 32'(1'b1));

    // NOP leaves q alone
    issue(C_NOP, 4'd5, 8'h12);
    chk_status("nop", 8'h7F, 1'b0, 1'b1, 1'b1);

    // CLEAR then serial fill 1,0,1,1,0,0,1,0 via SHL 8
    issue(C_CLR, 4'd0, 8'hFF);
    chk_status("clear", 8'h00, 1'b0, 1'b1, 1'b1);
    bits  = 8'b1011_0010;
    exp_q = 8'h00;
    si_l  = bits[7];
    exp_q = {exp_q[6:0], bits[7]};
    issue(C_SHL, 4'd8, 8'h00);
    chk("fill_q_0", 32'(q), 32'(exp_q));
    chk("fill_so_l_0", 32'(so_l), 32'(exp_q[7]));
    for (int i = 1; i < 8; i++) begin
      si_l  = bits[7-i];
      exp_q = {exp_q[6:0], bits[7-i]};
      tick();
      chk($sformatf("fill_q_%0d", i), 32'(q), 32'(exp_q));
      chk($sformatf("fill_so_l_%0d", i), 32'(so_l), 32'(exp_q[7]));
    end
    chk_status("fill_done", 8'hB2, 1'b0, 1'b1, 1'b1);

    // ROR 2 with cmd_valid held; LOAD 3C ignored while busy, taken at done
    cmd_valid = 1'b1;
    op        = C_ROR;
    amount    = 4'd2;
    tick();
    chk_status("ror2_s1", 8'h59, 1'b1, 1'b0, 1'b0);
    op     = C_LOAD;
    amount = 4'd0;
    pdata  = 8'h3C;
    tick();
    chk_status("ror2_done", 8'hAC, 1'b0, 1'b1, 1'b1);
    tick();
    cmd_valid = 1'b0;
    chk_status("b2b_load", 8'h3C, 1'b0, 1'b1, 1'b1);

    // SHL 0 leaves q unchanged
    si_l = 1'b1;
    issue(C_SHL, 4'd0, 8'h00);
    chk_status("shl0", 8'h3C, 1'b0, 1'b1, 1'b1);

    // ROL 15 on 0x01
    issue(C_LOAD, 4'd0, 8'h01);
    issue(C_ROL, 4'd15, 8'h00);
    chk_status("rol15_s1", 8'h02, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 13; i++) tick();
    chk_status("rol15_s14", 8'h40, 1'b1, 1'b0, 1'b0);
    tick();
    chk_status("rol15_done", 8'h80, 1'b0, 1'b1, 1'b1);

    // Async reset mid-burst
    issue(C_ROL, 4'd5, 8'h00);
    tick();
    chk("pre_rst_busy", 32'(busy), 32'(1'b1));
    #2 clr = 1'b0;
    #1;
    chk_status("mid_rst", 8'h00, 1'b0, 1'b0, 1'b1);
    #2 clr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("post_rst_done_%0d", i), 32'(done), 32'(1'b0));
    end
    chk_status("post_rst", 8'h00, 1'b0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
